// File: rtl/pdh_frame_capture.sv
// Captures one frame of FRAME_LEN decimated sample words and streams it out over
// AXI-Stream through a small FIFO; sticky finished/overflow flags report the outcome.
module pdh_frame_capture #(
    parameter int DATA_WIDTH = 64,
    parameter int FRAME_LEN  = 1024,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [25:0]           decimation_code_i,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  engaged_o,
    output logic                  finished_o,
    output logic                  overflow_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] FRAME_LEN_C = CW'(FRAME_LEN);

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic            en_prev_q, en_prev_d;
    logic [25:0]     dec_q, dec_d;
    logic [25:0]     dec_cnt_q, dec_cnt_d;
    logic [CW-1:0]   smp_cnt_q, smp_cnt_d;
    logic            engaged_q, engaged_d;
    logic            finished_q, finished_d;
    logic            overflow_q, overflow_d;
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;

    logic [DATA_WIDTH-1:0] mem_q  [FIFO_DEPTH];
    logic                  last_q [FIFO_DEPTH];

    logic fifo_empty, fifo_full, pop, push, sample, push_last, rise;

    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        // tvalid comes from registered pointers only, never from tready
        m_axis_tvalid = !fifo_empty;
        m_axis_tdata  = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
        m_axis_tlast  = !fifo_empty && last_q[rd_ptr_q[AW-1:0]];
        pop       = m_axis_tvalid && m_axis_tready;
        rise      = enable_i && !en_prev_q;
        sample    = (state_q == CAPTURE) && (dec_cnt_q == 26'd0);
        // a full FIFO still accepts a word when the head leaves on the same edge
        push      = sample && (!fifo_full || pop);
        push_last = ((smp_cnt_q + CW'(1)) == FRAME_LEN_C);
    end

    always_comb begin
        state_d    = state_q;
        en_prev_d  = enable_i;
        dec_d      = dec_q;
        dec_cnt_d  = dec_cnt_q;
        smp_cnt_d  = smp_cnt_q;
        finished_d = finished_q;
        overflow_d = overflow_q;
        wr_ptr_d   = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d   = rd_ptr_q + (AW+1)'(pop);
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d    = CAPTURE;
                    dec_d      = (decimation_code_i == 26'd0) ? 26'd1 : decimation_code_i;
                    dec_cnt_d  = '0;
                    smp_cnt_d  = '0;
                    finished_d = 1'b0;
                    overflow_d = 1'b0;
                end
            end
            CAPTURE: begin
                dec_cnt_d = (dec_cnt_q == dec_q - 26'd1) ? 26'd0 : dec_cnt_q + 26'd1;
                if (sample && !push) overflow_d = 1'b1;
                if (push) begin
                    smp_cnt_d = smp_cnt_q + CW'(1);
                    if (push_last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && m_axis_tlast) begin
                    state_d    = DONE;
                    finished_d = 1'b1;
                end
            end
            DONE: begin
                if (!enable_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        engaged_d = (state_d == CAPTURE) || (state_d == DRAIN);
    end

    // en_prev resets high so an enable already asserted at release is not an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            en_prev_q  <= 1'b1;
            dec_q      <= 26'd1;
            dec_cnt_q  <= '0;
            smp_cnt_q  <= '0;
            engaged_q  <= 1'b0;
            finished_q <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            en_prev_q  <= en_prev_d;
            dec_q      <= dec_d;
            dec_cnt_q  <= dec_cnt_d;
            smp_cnt_q  <= smp_cnt_d;
            engaged_q  <= engaged_d;
            finished_q <= finished_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]]  <= data_i;
            last_q[wr_ptr_q[AW-1:0]] <= push_last;
        end
    end

    assign engaged_o  = engaged_q;
    assign finished_o = finished_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_pdh_frame_capture.sv
// Frame-level bench: a vector table of frame configurations checked through an
// expected-beat scoreboard, plus hand-written reset and re-arm sequences.
module tb_pdh_frame_capture;

    localparam int DW = 32;
    localparam int FL = 32;
    localparam int FD = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable_i;
    logic [DW-1:0] data_i;
    logic [25:0]   code;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          engaged_o;
    logic          finished_o;
    logic          overflow_o;

    pdh_frame_capture #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .FIFO_DEPTH(FD)) dut (
        .clk               (clk),
        .rst               (rst),
        .enable_i          (enable_i),
        .data_i            (data_i),
        .decimation_code_i (code),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tready     (m_axis_tready),
        .m_axis_tlast      (m_axis_tlast),
        .engaged_o         (engaged_o),
        .finished_o        (finished_o),
        .overflow_o        (overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    typedef struct {
        logic [25:0] code;
        bit          rnd_ready;
        bit          stall40;
        bit          exp_ovf;
        bit          chk_data;
    } vec_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          beat_cnt = 0;
    int          last_cnt = 0;
    bit          check_data = 1'b1;
    bit          rnd_ready = 1'b0;
    int unsigned cyc = 0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // data_i is a free-running count so every beat value is predictable
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        data_i = cyc;
        if (rnd_ready) m_axis_tready = 1'($urandom_range(0, 1));
    endtask

    // Inputs only move just after posedge, so a negedge view predicts the next edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!(m_axis_tvalid && m_axis_tdata == prev_data && m_axis_tlast == prev_last)) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%0b data=%0h last=%0b held data=%0h last=%0b",
                             m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_data, prev_last);
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                beat_cnt++;
                if (m_axis_tlast) last_cnt++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat: got data=%0h with no beat expected", m_axis_tdata);
                end else begin
                    mon_e = sb.pop_front();
                    if (m_axis_tlast != mon_e.last || (check_data && m_axis_tdata != mon_e.data)) begin
                        errors++;
                        $display("FAIL beat %0d: got data=%0h last=%0b expected data=%0h last=%0b",
                                 beat_cnt, m_axis_tdata, m_axis_tlast, mon_e.data, mon_e.last);
                    end
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end
    end

    // Re-arm enable, queue the expected beats, and raise enable. The rising edge
    // is seen on the next posedge; the first sample is the data of the cycle after.
    task automatic start_frame(input logic [25:0] c, input bit dchk);
        exp_t e;
        int   dv;
        enable_i = 1'b0;
        tick();
        tick();
        dv = (c == 26'd0) ? 1 : int'(c);
        check_data = dchk;
        beat_cnt = 0;
        last_cnt = 0;
        code = c;
        for (int i = 0; i < FL; i++) begin
            e.data = data_i + DW'(1 + i * dv);
            e.last = (i == FL - 1);
            sb.push_back(e);
        end
        enable_i = 1'b1;
        tick();
        chk("start_engaged", engaged_o, 1);
        chk("start_finished_clear", finished_o, 0);
        chk("start_overflow_clear", overflow_o, 0);
        code = c + 26'd5;
    endtask

    task automatic run_frame(input vec_t v);
        int n;
        start_frame(v.code, v.chk_data);
        if (v.stall40) begin
            m_axis_tready = 1'b0;
            for (int i = 0; i < 40; i++) tick();
            m_axis_tready = 1'b1;
        end
        rnd_ready = v.rnd_ready;
        n = 0;
        while (!finished_o && n < 3000) begin
            tick();
            n++;
        end
        rnd_ready = 1'b0;
        m_axis_tready = 1'b1;
        chk("frame_finished", finished_o, 1);
        chk("frame_beats", beat_cnt, FL);
        chk("frame_tlast_count", last_cnt, 1);
        chk("frame_engaged_after", engaged_o, 0);
        chk("frame_overflow", overflow_o, v.exp_ovf);
        chk("frame_sb_empty", sb.size(), 0);
    endtask

    vec_t tbl[5];

    initial begin
        int n;
        int eng_seen;
        tbl[0] = '{code: 26'd0, rnd_ready: 1'b0, stall40: 1'b0, exp_ovf: 1'b0, chk_data: 1'b1};
        tbl[1] = '{code: 26'd1, rnd_ready: 1'b0, stall40: 1'b0, exp_ovf: 1'b0, chk_data: 1'b1};
        tbl[2] = '{code: 26'd4, rnd_ready: 1'b0, stall40: 1'b0, exp_ovf: 1'b0, chk_data: 1'b1};
        tbl[3] = '{code: 26'd3, rnd_ready: 1'b1, stall40: 1'b0, exp_ovf: 1'b0, chk_data: 1'b1};
        tbl[4] = '{code: 26'd1, rnd_ready: 1'b0, stall40: 1'b1, exp_ovf: 1'b1, chk_data: 1'b0};

        rst = 1'b1;
        enable_i = 1'b0;
        data_i = '0;
        code = 26'd1;
        m_axis_tready = 1'b1;
        #1;
        chk("reset_tvalid", m_axis_tvalid, 0);
        chk("reset_tlast", m_axis_tlast, 0);
        chk("reset_tdata", m_axis_tdata, 0);
        chk("reset_engaged", engaged_o, 0);
        chk("reset_finished", finished_o, 0);
        chk("reset_overflow", overflow_o, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int k = 0; k < 5; k++) run_frame(tbl[k]);

        // enable held high in DONE must not retrigger
        eng_seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (engaged_o) eng_seen++;
        end
        chk("held_enable_no_restart", eng_seen, 0);
        chk("held_enable_finished_sticky", finished_o, 1);
        run_frame(tbl[1]);

        // reset in the middle of a frame after three beats
        start_frame(26'd1, 1'b1);
        n = 0;
        while (beat_cnt < 3 && n < 200) begin
            tick();
            n++;
        end
        chk("beats_before_rst", beat_cnt >= 3, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_tvalid", m_axis_tvalid, 0);
        chk("midrst_tlast", m_axis_tlast, 0);
        chk("midrst_tdata", m_axis_tdata, 0);
        chk("midrst_engaged", engaged_o, 0);
        chk("midrst_finished", finished_o, 0);
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
        eng_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (engaged_o || m_axis_tvalid) eng_seen++;
        end
        chk("enable_high_at_release_no_start", eng_seen, 0);
        run_frame(tbl[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
